// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-unit definitions: boot PC, instruction width, FSM encodings, queue entry layout.
package instr_fetch_unit_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'd4096;
  localparam int          INSTR_W      = 32;

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } ifq_entry_t;
endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Small show-ahead FIFO with async reset and a synchronous clear that wins over push/pop.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [W-1:0]     din_i,
  input  logic             pop_i,
  output logic [W-1:0]     dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  // A full queue still accepts a push when the head leaves the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: credit-limited in-order imem reads, PC-tagged fetch queue, redirect flush.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2,
  parameter int          CNT_W    = 2
) (
  input  logic               clk,
  input  logic               resetPC,
  input  logic [31:0]        pc_cur,
  output logic [31:0]        pc_next,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               imem_req_valid,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               ifq_valid,
  output logic [INSTR_W-1:0] ifq_instr,
  output logic [31:0]        ifq_pc,
  input  logic               ifq_ready
);
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] outst_q, outst_d, drop_q, drop_d;
  logic [CNT_W-1:0] occ, tag_cnt;
  logic [CNT_W:0]   inflight_sum;
  logic             fire, resp, push, pop;
  logic             q_full, q_empty, tag_full, tag_empty;
  logic [31:0]      tag_head;
  ifq_entry_t       wr_ent, head;

  // Credits: queued words plus reads in flight never exceed the queue depth.
  assign inflight_sum   = {1'b0, occ} + {1'b0, outst_q};
  assign imem_req_valid = ~resetPC & (state_q == S_FETCH) &
                          (inflight_sum < (CNT_W+1)'(DEPTH)) & ~redirect_valid;
  assign imem_req_addr  = pc_cur & ~32'd3;
  assign fire = imem_req_valid & imem_req_ready;
  assign resp = imem_resp_valid;
  assign push = resp & (drop_q == '0) & ~redirect_valid;
  assign pop  = ifq_valid & ifq_ready;

  always_comb begin
    if (resetPC)             pc_next = RESET_PC;
    else if (redirect_valid) pc_next = redirect_pc & ~32'd3;
    else if (fire)           pc_next = pc_cur + 32'd4;
    else                     pc_next = pc_cur;
  end

  always_comb begin
    outst_d = outst_q;
    case ({fire, resp})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase
    // Everything still in flight after a redirect belongs to the old path.
    drop_d = drop_q;
    if (redirect_valid)               drop_d = outst_d;
    else if (resp && drop_q != '0)    drop_d = drop_q - CNT_W'(1);
    state_d = state_q;
    case (state_q)
      S_FETCH: if (redirect_valid && outst_d != '0) state_d = S_FLUSH;
      default: if (drop_d == '0)                    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge resetPC) begin
    if (resetPC) begin
      state_q <= S_FETCH;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  // Tags are never cleared: each outstanding read retires its tag when it returns.
  fetch_queue #(.DEPTH(DEPTH), .W(32), .CNT_W(CNT_W)) u_tag_q (
    .clk(clk), .rst_i(resetPC), .clr_i(1'b0),
    .push_i(fire), .din_i(pc_cur), .pop_i(resp), .dout_o(tag_head),
    .full_o(tag_full), .empty_o(tag_empty), .count_o(tag_cnt)
  );

  assign wr_ent = '{pc: tag_head, instr: imem_resp_data};

  fetch_queue #(.DEPTH(DEPTH), .W($bits(ifq_entry_t)), .CNT_W(CNT_W)) u_ifq (
    .clk(clk), .rst_i(resetPC), .clr_i(redirect_valid),
    .push_i(push), .din_i(wr_ent), .pop_i(pop), .dout_o(head),
    .full_o(q_full), .empty_o(q_empty), .count_o(occ)
  );

  assign ifq_valid = ~q_empty;
  assign ifq_pc    = head.pc;
  assign ifq_instr = head.instr;

  a_resp_expected: assert property (@(posedge clk) disable iff (resetPC)
    resp |-> (outst_q != '0) && !tag_empty);
  a_tags_track:    assert property (@(posedge clk) disable iff (resetPC)
    tag_cnt == outst_q);
  a_no_overflow:   assert property (@(posedge clk) disable iff (resetPC)
    !(fire && tag_full) && !(push && q_full && !pop));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + random bench for instr_fetch_unit with a queue-based reference model and memory model.
module tb_instr_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0, resetPC = 1'b0;
  logic [31:0] pc_cur, pc_next, redirect_pc, imem_req_addr, imem_resp_data, ifq_instr, ifq_pc;
  logic        redirect_valid, imem_req_valid, imem_req_ready, imem_resp_valid, ifq_valid, ifq_ready;

  int vectors = 0, miscompares = 0;
  int mem_mode;  // 0: 1-cycle latency, 1: random latency, 2: stalled

  logic [31:0] mem_q[$];
  logic [31:0] m_infl[$];
  logic [63:0] m_ifq[$];
  int          m_drop;
  logic [31:0] fire_log[$], pop_log[$];
  logic [31:0] last_addr, last_next;
  logic        last_req, last_ifqv;
  logic [31:0] base;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH), .CNT_W(2)) dut (
    .clk(clk), .resetPC(resetPC), .pc_cur(pc_cur), .pc_next(pc_next),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .ifq_valid(ifq_valid), .ifq_instr(ifq_instr), .ifq_pc(ifq_pc), .ifq_ready(ifq_ready)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_at(input string tag, input logic [31:0] q[$], input int i, input logic [31:0] exp);
    vectors++;
    assert (i < q.size() && q[i] === exp) else begin
      miscompares++;
      $error("FAIL %s: entry %0d got %h expected %h", tag, i, (i < q.size()) ? q[i] : 32'hx, exp);
    end
  endtask

  task automatic clear_model();
    m_infl.delete(); m_ifq.delete(); m_drop = 0; mem_q.delete();
  endtask

  task automatic clear_logs();
    fire_log.delete(); pop_log.delete();
  endtask

  // One clock: drive at posedge+1, check at posedge+2, advance model/memory/PC register after the edge.
  task automatic step(input logic rdir, input logic [31:0] rpc, input logic rdy, input logic iq_rdy);
    logic        e_req, e_fire, e_resp, e_pop, s_fire;
    logic [31:0] e_next, s_next, s_addr, rpc_al, pc;
    redirect_valid = rdir; redirect_pc = rpc; imem_req_ready = rdy; ifq_ready = iq_rdy;
    e_resp = 1'b0;
    if (!resetPC && mem_q.size() > 0)
      case (mem_mode)
        0:       e_resp = 1'b1;
        1:       e_resp = ($urandom_range(0, 1) == 1);
        default: e_resp = 1'b0;
      endcase
    imem_resp_valid = e_resp;
    imem_resp_data  = e_resp ? instr_of(mem_q[0]) : $urandom;
    #1;
    rpc_al = {rpc[31:2], 2'b00};
    e_req  = !resetPC && m_drop == 0 && (m_ifq.size() + m_infl.size() < DEPTH) && !rdir;
    e_fire = e_req && rdy;
    e_next = rdir ? rpc_al : (e_fire ? pc_cur + 32'd4 : pc_cur);
    chk("req_valid", 32'(imem_req_valid), 32'(e_req));
    if (e_req) chk("req_addr", imem_req_addr, {pc_cur[31:2], 2'b00});
    chk("pc_next", pc_next, e_next);
    chk("ifq_valid", 32'(ifq_valid), 32'(m_ifq.size() > 0));
    if (m_ifq.size() > 0) begin
      chk("ifq_pc", ifq_pc, m_ifq[0][63:32]);
      chk("ifq_instr", ifq_instr, m_ifq[0][31:0]);
    end
    e_pop  = (m_ifq.size() > 0) && iq_rdy;
    s_fire = imem_req_valid & imem_req_ready;
    s_addr = imem_req_addr;
    s_next = pc_next;
    last_addr = s_addr; last_next = s_next; last_req = imem_req_valid; last_ifqv = ifq_valid;
    if (s_fire) fire_log.push_back(s_addr);
    if (ifq_valid && iq_rdy) pop_log.push_back(ifq_pc);
    @(posedge clk); #1;
    if (resetPC) begin
      clear_model();
      pc_cur = RST_PC;
    end else begin
      if (e_pop) void'(m_ifq.pop_front());
      if (e_resp && m_infl.size() > 0) begin
        pc = m_infl.pop_front();
        if (m_drop > 0) m_drop--;
        else if (!rdir) m_ifq.push_back({pc, instr_of(pc)});
      end
      if (e_fire) m_infl.push_back(pc_cur);
      if (rdir) begin
        m_ifq.delete();
        m_drop = m_infl.size();
      end
      if (e_resp) void'(mem_q.pop_front());
      if (s_fire) mem_q.push_back(s_addr);
      pc_cur = s_next;
    end
    redirect_valid = 1'b0;
    imem_resp_valid = 1'b0;
  endtask

  initial begin
    redirect_valid = 0; redirect_pc = 0; imem_req_ready = 0; imem_resp_valid = 0;
    imem_resp_data = 0; ifq_ready = 0; pc_cur = RST_PC; mem_mode = 0;
    clear_model(); clear_logs();
    #2 resetPC = 1'b1;
    @(posedge clk); #1;
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    chk("rst_req_valid", 32'(last_req), 32'd0);
    chk("rst_ifq_valid", 32'(last_ifqv), 32'd0);
    chk("rst_pc_next", last_next, RST_PC);
    resetPC = 1'b0;

    // Streaming from boot PC with 1-cycle memory.
    clear_logs();
    repeat (10) step(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      chk_at("t1_fire", fire_log, i, RST_PC + 32'(4 * i));
      chk_at("t1_pop", pop_log, i, RST_PC + 32'(4 * i));
    end

    // Decode stalled: credits run out after DEPTH fires, then resume in order.
    repeat (4) step(0, 0, 0, 1);
    base = pc_cur;
    clear_logs();
    repeat (8) step(0, 0, 1, 0);
    chk("t2_nfires", 32'(fire_log.size()), 32'd2);
    chk_at("t2_fire", fire_log, 0, base);
    chk_at("t2_fire", fire_log, 1, base + 32'd4);
    chk("t2_req_valid", 32'(last_req), 32'd0);
    chk("t2_pc_hold", last_next, base + 32'd8);
    repeat (12) step(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) chk_at("t2_seq", pop_log, i, base + 32'(4 * i));

    // Memory not ready: request address and PC hold.
    repeat (3) step(0, 0, 0, 1);
    base = pc_cur;
    repeat (5) begin
      step(0, 0, 0, 1);
      chk("t5_addr", last_addr, base);
      chk("t5_pc_hold", last_next, base);
    end
    chk("t5_req_valid", 32'(last_req), 32'd1);

    // Redirect with two reads outstanding; stale words are dropped.
    repeat (4) step(0, 0, 0, 1);
    mem_mode = 2;
    repeat (3) step(0, 0, 1, 1);
    mem_mode = 0;
    clear_logs();
    step(1, 32'h0000_2002, 1, 1);
    chk("t3_pc_next", last_next, 32'h0000_2000);
    repeat (8) step(0, 0, 1, 1);
    chk_at("t3_first_fire", fire_log, 0, 32'h0000_2000);
    chk_at("t3_first_pop", pop_log, 0, 32'h0000_2000);

    // PC wrap at the top of the address space.
    clear_logs();
    step(1, 32'hFFFF_FFFC, 1, 1);
    repeat (8) step(0, 0, 1, 1);
    chk_at("t4_fire_top", fire_log, 0, 32'hFFFF_FFFC);
    chk_at("t4_fire_wrap", fire_log, 1, 32'h0000_0000);
    chk_at("t4_pop_top", pop_log, 0, 32'hFFFF_FFFC);

    // Reset while flushing.
    repeat (4) step(0, 0, 0, 1);
    mem_mode = 2;
    repeat (3) step(0, 0, 1, 1);
    step(1, 32'h0000_3000, 1, 1);
    step(0, 0, 1, 1);
    resetPC = 1'b1;
    pc_cur  = RST_PC;
    clear_model();
    step(0, 0, 1, 1);
    chk("t6_req_valid", 32'(last_req), 32'd0);
    chk("t6_ifq_valid", 32'(last_ifqv), 32'd0);
    chk("t6_pc_next", last_next, RST_PC);
    resetPC = 1'b0;
    mem_mode = 0;
    clear_logs();
    repeat (4) step(0, 0, 1, 1);
    chk_at("t6_first_fire", fire_log, 0, RST_PC);

    // Random traffic: redirects, backpressure on both sides, variable latency.
    mem_mode = 1;
    repeat (400)
      step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
